sram_req_sequencer: RTL and testbench

- Processor-side request stage that sits directly upstream of the SRAM controller.
- Accepts single-beat read/write requests over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each request onto the controller's address, data and strobe pins with fixed setup/access/recovery timing, retries on controller-reported errors, and returns one response per request.

---
 rtl/sram_pkg.sv | 36 +++
 rtl/sram_req_fifo.sv | 76 +++++++
 rtl/sram_req_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sram_req_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared FSM state encoding, request record and address
//                constants for the SRAM request sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE    = 3'd0;
    localparam state_t c_SETUP   = 3'd1;
    localparam state_t c_ACCESS  = 3'd2;
    localparam state_t c_RECOVER = 3'd3;
    localparam state_t c_RESP    = 3'd4;

    // The sequencer's ADDR_W/DATA_W must match these widths.
    typedef struct packed {
        logic                we;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } sram_req_t;

    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = '1;

    // Writes to the top address are rejected without touching the controller.
    function automatic logic is_skip(input sram_req_t req);
        return req.we && (req.addr == c_LAST_ADDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_fifo
//  Description : Parameterised single-clock FIFO with count, full and empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0] r_count_q,  w_count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count_q == CNT_W'(DEPTH));
    assign o_empty   = (r_count_q == '0);
    assign o_count   = r_count_q;
    assign o_data    = r_mem_q[r_rd_ptr_q];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + CNT_W'(1);
            2'b01:   w_count_d = r_count_q - CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_sequencer
//  Description : Queues single-beat read/write requests and sequences them
//                onto the SRAM controller pins with setup/access/recovery
//                timing, bounded retries and one response per request.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_sequencer
    import sram_pkg::*;
#(
    parameter int ADDR_W        = c_ADDR_W,
    parameter int DATA_W        = c_DATA_W,
    parameter int DEPTH         = 4,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_RETRIES   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    output logic              ctl_we_n,
    output logic              ctl_oe_n,
    input  logic [DATA_W-1:0] ctl_rdata,
    input  logic              ctl_error,
    input  logic              ctl_denied,
    output logic              busy
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int ACC_W   = (ACCESS_CYCLES < 2) ? 1 : $clog2(ACCESS_CYCLES);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [RETRY_W-1:0] c_RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [ACC_W-1:0]   c_ACC_LAST  = ACC_W'(ACCESS_CYCLES - 1);

    sram_req_t          w_push_req;
    sram_req_t          w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;

    state_t             r_state_q, w_state_d;
    sram_req_t          r_cmd_q,   w_cmd_d;
    logic [ACC_W-1:0]   r_acc_q,   w_acc_d;
    logic [RETRY_W-1:0] r_retry_q, w_retry_d;
    logic [DATA_W-1:0]  r_rdata_q, w_rdata_d;
    logic               r_err_q,   w_err_d;

    assign req_ready  = !rst && !w_full;
    assign w_push     = req_valid && req_ready;
    assign w_push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

    sram_req_fifo #(
        .WIDTH ($bits(sram_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_cmd_d   = r_cmd_q;
        w_acc_d   = r_acc_q;
        w_retry_d = r_retry_q;
        w_rdata_d = r_rdata_q;
        w_err_d   = r_err_q;
        w_pop     = 1'b0;
        case (r_state_q)
            c_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_cmd_d   = w_head;
                    w_rdata_d = '0;
                    w_err_d   = 1'b0;
                    w_state_d = c_SETUP;
                end
            end
            c_SETUP: begin
                if (is_skip(r_cmd_q)) begin
                    w_err_d   = 1'b1;
                    w_state_d = c_RESP;
                end else begin
                    w_acc_d   = '0;
                    w_state_d = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (r_acc_q == c_ACC_LAST) begin
                    if (!r_cmd_q.we) begin
                        w_rdata_d = ctl_rdata;
                    end
                    w_state_d = c_RECOVER;
                end else begin
                    w_acc_d = r_acc_q + ACC_W'(1);
                end
            end
            c_RECOVER: begin
                // Denial is final; errors are retried until the budget runs out.
                if (ctl_denied) begin
                    w_err_d   = 1'b1;
                    w_state_d = c_RESP;
                end else if (ctl_error && (r_retry_q < c_RETRY_MAX)) begin
                    w_retry_d = r_retry_q + RETRY_W'(1);
                    w_state_d = c_SETUP;
                end else begin
                    w_err_d   = ctl_error;
                    w_state_d = c_RESP;
                end
            end
            c_RESP: begin
                w_retry_d = '0;
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_IDLE;
            r_cmd_q   <= '0;
            r_acc_q   <= '0;
            r_retry_q <= '0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cmd_q   <= w_cmd_d;
            r_acc_q   <= w_acc_d;
            r_retry_q <= w_retry_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
        end
    end

    // The command register holds its value until the next pop.
    assign ctl_addr  = r_cmd_q.addr;
    assign ctl_wdata = r_cmd_q.wdata;
    assign ctl_we_n  = !((r_state_q == c_ACCESS) && r_cmd_q.we);
    assign ctl_oe_n  = !((r_state_q == c_ACCESS) && !r_cmd_q.we);

    assign rsp_valid = (r_state_q == c_RESP);
    assign rsp_rdata = rsp_valid ? r_rdata_q : '0;
    assign rsp_err   = rsp_valid && r_err_q;
    assign busy      = (w_count != '0) || (r_state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_req_sequencer
//  Description : Self-checking bench with an SRAM controller model and a
//                per-request response model for sram_req_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_sequencer;

    localparam int MAX_RETRIES = 3;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          n_err;
        bit          deny;
        int          hs;
    } plan_t;

    typedef struct {
        plan_t       p;
        logic [7:0]  rdata;
        logic        err;
        int          pulses;
        int          low_cycles;
        int          first_low;
        int          rsp_cyc;
        logic [7:0]  last_rd;
        bit          addr_ok;
        bit          kind_ok;
    } got_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] ctl_addr;
    logic [7:0]  ctl_wdata;
    logic        ctl_we_n;
    logic        ctl_oe_n;
    logic [7:0]  ctl_rdata = '0;
    logic        ctl_error = 1'b0;
    logic        ctl_denied = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    plan_t plan_q[$];
    got_t  got_q[$];

    int         pulse_cnt = 0;
    int         low_cnt = 0;
    int         first_low = -1;
    bit         prev_high = 1'b1;
    bit         addr_ok = 1'b1;
    bit         kind_ok = 1'b1;
    logic [7:0] last_rd = '0;
    bit         use_override = 1'b0;
    logic [7:0] rd_override = '0;
    int         both_low = 0;
    int         stray_strobe = 0;
    int         stray_rsp = 0;

    sram_req_sequencer #(
        .ADDR_W        (16),
        .DATA_W        (8),
        .DEPTH         (4),
        .ACCESS_CYCLES (2),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ctl_addr   (ctl_addr),
        .ctl_wdata  (ctl_wdata),
        .ctl_we_n   (ctl_we_n),
        .ctl_oe_n   (ctl_oe_n),
        .ctl_rdata  (ctl_rdata),
        .ctl_error  (ctl_error),
        .ctl_denied (ctl_denied),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: counts strobe pulses, supplies read data, and answers
    // each recovery cycle with the error/deny pattern of the request in service.
    always @(negedge clk) begin
        logic  strobe_low;
        plan_t cur;
        got_t  g;
        if (rst) begin
            pulse_cnt = 0; low_cnt = 0; first_low = -1; prev_high = 1'b1;
            addr_ok = 1'b1; kind_ok = 1'b1; last_rd = '0;
            ctl_error = 1'b0; ctl_denied = 1'b0;
        end else begin
            strobe_low = !ctl_we_n || !ctl_oe_n;
            if (!ctl_we_n && !ctl_oe_n) both_low++;
            ctl_error  = 1'b0;
            ctl_denied = 1'b0;
            if (strobe_low) begin
                if (plan_q.size() == 0) begin
                    stray_strobe++;
                end else begin
                    cur = plan_q[0];
                    low_cnt++;
                    if (first_low < 0) first_low = cyc;
                    if (ctl_addr !== cur.addr || (cur.we && ctl_wdata !== cur.wdata)) addr_ok = 1'b0;
                    if (cur.we ? (ctl_we_n !== 1'b0) : (ctl_oe_n !== 1'b0)) kind_ok = 1'b0;
                    if (prev_high) begin
                        pulse_cnt++;
                        if (!cur.we) begin
                            ctl_rdata = use_override ? rd_override : 8'($urandom);
                            last_rd   = ctl_rdata;
                        end
                    end
                end
            end else if (!prev_high && plan_q.size() > 0) begin
                ctl_error  = (pulse_cnt <= plan_q[0].n_err);
                ctl_denied = plan_q[0].deny;
            end
            prev_high = !strobe_low;
            if (rsp_valid) begin
                if (plan_q.size() == 0) begin
                    stray_rsp++;
                end else begin
                    g.p = plan_q.pop_front();
                    g.rdata = rsp_rdata; g.err = rsp_err; g.pulses = pulse_cnt;
                    g.low_cycles = low_cnt; g.first_low = first_low; g.rsp_cyc = cyc;
                    g.last_rd = last_rd; g.addr_ok = addr_ok; g.kind_ok = kind_ok;
                    got_q.push_back(g);
                end
                pulse_cnt = 0; low_cnt = 0; first_low = -1;
                addr_ok = 1'b1; kind_ok = 1'b1; last_rd = '0;
            end
        end
    end

    function automatic bit is_skip_req(plan_t p);
        return p.we && (p.addr == 16'hFFFF);
    endfunction

    function automatic int exp_pulses(plan_t p);
        if (is_skip_req(p)) return 0;
        if (p.deny) return 1;
        return (p.n_err > MAX_RETRIES) ? MAX_RETRIES + 1 : p.n_err + 1;
    endfunction

    function automatic logic exp_err(plan_t p);
        return is_skip_req(p) || p.deny || (p.n_err > MAX_RETRIES);
    endfunction

    function automatic int exp_latency(plan_t p);
        if (is_skip_req(p)) return 3;
        return 6 + (exp_pulses(p) - 1) * 4;
    endfunction

    task automatic push(input plan_t p, output int hs);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = p.we; req_addr = p.addr; req_wdata = p.wdata;
        while (!req_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        hs = cyc;
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
        end else begin
            p.hs = cyc;
            plan_q.push_back(p);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (got_q.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 600) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 10'h0) begin bad++; $display("FAIL rst_rsp: got %0b/%0b/%0h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if ({ctl_addr, ctl_wdata} !== 24'h0) begin bad++; $display("FAIL rst_ctl_bus: got %0h/%0h want 0/0", ctl_addr, ctl_wdata); end
        total++; if ({ctl_we_n, ctl_oe_n} !== 2'b11) begin bad++; $display("FAIL rst_strobes: got %0b%0b want 11", ctl_we_n, ctl_oe_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_single_write();
        plan_t p; got_t g; int hs;
        p = '{we: 1'b1, addr: 16'h0010, wdata: 8'h5A, n_err: 0, deny: 1'b0, hs: 0};
        push(p, hs);
        wait_rsp(1);
        total++;
        if (got_q.size() != 1) begin bad++; $display("FAIL wr_rsp_count: got %0d want 1", got_q.size()); return; end
        g = got_q.pop_front();
        total++; if (g.rsp_cyc - hs !== 6) begin bad++; $display("FAIL wr_latency: got %0d want 6", g.rsp_cyc - hs); end
        total++; if (g.first_low - hs !== 3) begin bad++; $display("FAIL wr_strobe_start: got %0d want 3", g.first_low - hs); end
        total++; if (g.low_cycles !== 2) begin bad++; $display("FAIL wr_strobe_len: got %0d want 2", g.low_cycles); end
        total++; if (g.addr_ok !== 1'b1 || g.kind_ok !== 1'b1) begin bad++; $display("FAIL wr_ctl_pins: addr_ok=%0b kind_ok=%0b want 1/1", g.addr_ok, g.kind_ok); end
        total++; if (g.err !== 1'b0 || g.rdata !== 8'h00) begin bad++; $display("FAIL wr_rsp: err=%0b rdata=%0h want 0/00", g.err, g.rdata); end
        wait_idle();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_pulse_width: got %0b want 0", rsp_valid); end
    endtask

    task automatic test_single_read();
        plan_t p; got_t g; int hs;
        use_override = 1'b1; rd_override = 8'hC3;
        p = '{we: 1'b0, addr: 16'h0020, wdata: 8'h00, n_err: 0, deny: 1'b0, hs: 0};
        push(p, hs);
        wait_rsp(1);
        use_override = 1'b0;
        total++;
        if (got_q.size() != 1) begin bad++; $display("FAIL rd_rsp_count: got %0d want 1", got_q.size()); return; end
        g = got_q.pop_front();
        total++; if (g.rdata !== 8'hC3) begin bad++; $display("FAIL rd_data: got %0h want c3", g.rdata); end
        total++; if (g.err !== 1'b0) begin bad++; $display("FAIL rd_err: got %0b want 0", g.err); end
        total++; if (g.low_cycles !== 2 || g.kind_ok !== 1'b1) begin bad++; $display("FAIL rd_strobe: len=%0d kind_ok=%0b want 2/1", g.low_cycles, g.kind_ok); end
        total++; if (g.rsp_cyc - hs !== 6) begin bad++; $display("FAIL rd_latency: got %0d want 6", g.rsp_cyc - hs); end
        wait_idle();
    endtask

    task automatic test_fifo_full();
        plan_t p; got_t g; int hs[6]; int prev_rsp;
        for (int i = 0; i < 6; i++) begin
            p = '{we: i[0], addr: 16'h0100 + 16'(i), wdata: 8'h10 + 8'(i), n_err: 0, deny: 1'b0, hs: 0};
            push(p, hs[i]);
        end
        // One entry drains straight into the command register, so five go in
        // without a stall and the sixth waits for the next pop.
        total++; if (hs[4] - hs[0] !== 4) begin bad++; $display("FAIL fifo_no_stall: got %0d want 4", hs[4] - hs[0]); end
        total++; if (hs[5] - hs[0] !== 8) begin bad++; $display("FAIL fifo_stall_release: got %0d want 8", hs[5] - hs[0]); end
        wait_rsp(6);
        total++;
        if (got_q.size() != 6) begin bad++; $display("FAIL fifo_rsp_count: got %0d want 6", got_q.size()); return; end
        prev_rsp = hs[0];
        for (int i = 0; i < 6; i++) begin
            g = got_q.pop_front();
            total++; if (g.addr_ok !== 1'b1 || g.kind_ok !== 1'b1 || g.pulses !== 1) begin bad++; $display("FAIL fifo_order[%0d]: addr_ok=%0b kind_ok=%0b pulses=%0d want 1/1/1", i, g.addr_ok, g.kind_ok, g.pulses); end
            total++; if (g.err !== 1'b0 || g.rdata !== (g.p.we ? 8'h00 : g.last_rd)) begin bad++; $display("FAIL fifo_rsp[%0d]: err=%0b rdata=%0h want 0/%0h", i, g.err, g.rdata, g.p.we ? 8'h00 : g.last_rd); end
            total++; if (g.rsp_cyc - prev_rsp !== 6) begin bad++; $display("FAIL fifo_spacing[%0d]: got %0d want 6", i, g.rsp_cyc - prev_rsp); end
            prev_rsp = g.rsp_cyc;
        end
        wait_idle();
    endtask

    task automatic test_retry();
        plan_t p; got_t g; int hs;
        int errs[2] = '{2, 1000};
        for (int t = 0; t < 2; t++) begin
            p = '{we: 1'(t), addr: 16'h0300 + 16'(t), wdata: 8'hA5, n_err: errs[t], deny: 1'b0, hs: 0};
            push(p, hs);
            wait_rsp(1);
            total++;
            if (got_q.size() != 1) begin bad++; $display("FAIL retry_rsp_count[%0d]: got %0d want 1", t, got_q.size()); return; end
            g = got_q.pop_front();
            total++; if (g.pulses !== exp_pulses(p)) begin bad++; $display("FAIL retry_pulses[%0d]: got %0d want %0d", t, g.pulses, exp_pulses(p)); end
            total++; if (g.err !== exp_err(p)) begin bad++; $display("FAIL retry_err[%0d]: got %0b want %0b", t, g.err, exp_err(p)); end
            total++; if (g.rsp_cyc - hs !== exp_latency(p)) begin bad++; $display("FAIL retry_latency[%0d]: got %0d want %0d", t, g.rsp_cyc - hs, exp_latency(p)); end
            wait_idle();
        end
    endtask

    task automatic test_addr_deny_errors();
        plan_t p; got_t g; int hs;
        p = '{we: 1'b1, addr: 16'hFFFF, wdata: 8'h77, n_err: 0, deny: 1'b0, hs: 0};
        push(p, hs);
        wait_rsp(1);
        total++;
        if (got_q.size() != 1) begin bad++; $display("FAIL skip_rsp_count: got %0d want 1", got_q.size()); return; end
        g = got_q.pop_front();
        total++; if (g.pulses !== 0 || g.first_low !== -1) begin bad++; $display("FAIL skip_no_strobe: pulses=%0d want 0", g.pulses); end
        total++; if (g.err !== 1'b1) begin bad++; $display("FAIL skip_err: got %0b want 1", g.err); end
        total++; if (g.rsp_cyc - hs !== 3) begin bad++; $display("FAIL skip_latency: got %0d want 3", g.rsp_cyc - hs); end
        wait_idle();
        p = '{we: 1'b0, addr: 16'h0400, wdata: 8'h00, n_err: 2, deny: 1'b1, hs: 0};
        push(p, hs);
        wait_rsp(1);
        total++;
        if (got_q.size() != 1) begin bad++; $display("FAIL deny_rsp_count: got %0d want 1", got_q.size()); return; end
        g = got_q.pop_front();
        total++; if (g.pulses !== 1 || g.err !== 1'b1) begin bad++; $display("FAIL deny: pulses=%0d err=%0b want 1/1", g.pulses, g.err); end
        total++; if (g.rdata !== g.last_rd) begin bad++; $display("FAIL deny_rdata: got %0h want %0h", g.rdata, g.last_rd); end
        wait_idle();
    endtask

    task automatic test_reset_mid_access();
        plan_t p; int hs; int k; int stray0;
        for (int i = 0; i < 3; i++) begin
            p = '{we: i[0], addr: 16'h0500 + 16'(i), wdata: 8'h33, n_err: 0, deny: 1'b0, hs: 0};
            push(p, hs);
        end
        k = 0;
        while (ctl_we_n && ctl_oe_n && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++; if (ctl_we_n && ctl_oe_n) begin bad++; $display("FAIL rstmid_no_access: strobes=%0b%0b want a low strobe", ctl_we_n, ctl_oe_n); end
        rst = 1'b1;
        plan_q.delete();
        @(posedge clk);
        #1;
        total++; if ({ctl_we_n, ctl_oe_n} !== 2'b11) begin bad++; $display("FAIL rstmid_strobes: got %0b%0b want 11", ctl_we_n, ctl_oe_n); end
        total++; if (busy !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL rstmid_busy_ready: busy=%0b ready=%0b want 0/0", busy, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        stray0 = stray_rsp;
        repeat (40) @(negedge clk);
        total++; if (got_q.size() != 0 || stray_rsp != stray0) begin bad++; $display("FAIL rstmid_no_rsp: got %0d responses want 0", got_q.size() + stray_rsp - stray0); end
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_after: busy=%0b ready=%0b want 0/1", busy, req_ready); end
    endtask

    task automatic test_random();
        plan_t p; got_t g; int hs; int n;
        n = 24;
        for (int i = 0; i < n; i++) begin
            p.we    = 1'($urandom_range(0, 1));
            p.addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            p.wdata = 8'($urandom);
            p.n_err = $urandom_range(0, 4);
            p.deny  = ($urandom_range(0, 7) == 0);
            p.hs    = 0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(p, hs);
        end
        wait_rsp(n);
        total++;
        if (got_q.size() != n) begin bad++; $display("FAIL rand_rsp_count: got %0d want %0d", got_q.size(), n); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            total++; if (g.err !== exp_err(g.p)) begin bad++; $display("FAIL rand_err addr=%0h: got %0b want %0b", g.p.addr, g.err, exp_err(g.p)); end
            total++; if (g.pulses !== exp_pulses(g.p)) begin bad++; $display("FAIL rand_pulses addr=%0h: got %0d want %0d", g.p.addr, g.pulses, exp_pulses(g.p)); end
            total++; if (g.rdata !== (g.p.we ? 8'h00 : g.last_rd)) begin bad++; $display("FAIL rand_rdata addr=%0h: got %0h want %0h", g.p.addr, g.rdata, g.p.we ? 8'h00 : g.last_rd); end
            total++; if (g.addr_ok !== 1'b1 || g.kind_ok !== 1'b1) begin bad++; $display("FAIL rand_ctl_pins addr=%0h: addr_ok=%0b kind_ok=%0b want 1/1", g.p.addr, g.addr_ok, g.kind_ok); end
        end
        wait_idle();
        total++; if (both_low != 0 || stray_strobe != 0 || stray_rsp != 0) begin bad++; $display("FAIL protocol: both_low=%0d stray_strobe=%0d stray_rsp=%0d want 0/0/0", both_low, stray_strobe, stray_rsp); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_fifo_full();
        test_retry();
        test_addr_deny_errors();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
